// File: rtl/fpadd_param.sv
// fpadd_param - parametrised floating-point add/subtract unit.
//
// Multi-cycle adder for packed {sign, exp, frac} operands at any exponent
// and fraction width. It uses round-to-nearest-even and a start/busy/done
// handshake. The datapath moves through IDLE -> ALIGN -> ADD -> NORM -> ROUND.
// NORM does one left shift per cycle.
//
// Results that need no left shift (carry-out, already normalised, exact zero,
// or a subnormal stop) go from ADD straight to ROUND. With this routing the
// latency is 4 + (number of left shifts) cycles.
//
// Build option:
//   FPADD_SUBNORMAL_EN  when defined, subnormal inputs and outputs are supported.
//                       Otherwise subnormal inputs read as zero and tiny results
//                       flush to a same-sign zero with inexact set.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts any operation
//   start  request, sampled only in IDLE
//   a, b   operands {sign, exp, frac}
//   sub    0: a+b, 1: a-b
//   sum    result, held until the next result is written
//   done   one-cycle pulse when sum/flags are updated
//   busy   high whenever the unit is not in IDLE
//   flags  {invalid, overflow, inexact}
module fpadd_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   done,
    output logic                   busy,
    output logic [2:0]             flags
);
    localparam int W         = EXP_W + MAN_W + 1;
    localparam int SIG_W     = MAN_W + 4;                      // hidden, frac, G, R, S
    localparam int EI_W      = EXP_W + $clog2(SIG_W) + 2;      // signed working exponent
    localparam int SHIFT_LIM = MAN_W + 3;                      // alignment distance leaving only sticky

`ifdef FPADD_SUBNORMAL_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    localparam logic [EXP_W-1:0]       EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]       EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0]       FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [SIG_W:0]         ADD_ZERO  = {(SIG_W+1){1'b0}};
    localparam logic [SIG_W-1:0]       SIG_ZERO  = {SIG_W{1'b0}};
    localparam logic signed [EI_W-1:0] EI_ONE    = {{(EI_W-1){1'b0}}, 1'b1};
    localparam logic signed [EI_W-1:0] EI_MAX    = {{(EI_W-EXP_W){1'b0}}, EXP_ONES};
    localparam logic [W-1:0]           QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4
    } state_t;

    // Zero test. A subnormal counts as zero when subnormal support is off.
    function automatic logic is_zero(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (e == EXP_ZERO) && ((f == FRAC_ZERO) || !SUB_EN);
    endfunction

    // Working exponent: subnormals sit at exponent 1 with a zero hidden bit.
    function automatic logic signed [EI_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == EXP_ZERO) ? EI_ONE : {{(EI_W-EXP_W){1'b0}}, e};
    endfunction

    // Right shift that folds every shifted-out bit into the sticky LSB.
    function automatic logic [SIG_W-1:0] shr_sticky(input logic [SIG_W-1:0] v,
                                                    input logic [EI_W-1:0]  d);
        logic [SIG_W-1:0] sh;
        logic             lost;
        if (d >= EI_W'(SHIFT_LIM)) begin
            return {{(SIG_W-1){1'b0}}, |v};
        end else begin
            sh   = v >> d;
            lost = |(v & ~({SIG_W{1'b1}} << d));
            return {sh[SIG_W-1:1], sh[0] | lost};
        end
    endfunction

    state_t                  state_r, state_nx_s;
    logic [W-1:0]            a_r, b_r;
    logic                    sub_r;
    logic [SIG_W-1:0]        x_r, y_r, mant_r;
    logic                    sx_r, sy_r, sign_r;
    logic signed [EI_W-1:0]  exp_r;
    logic [W-1:0]            sum_r;
    logic [2:0]              flags_r;
    logic                    done_r, busy_r;

    logic                    spec_hit_s;
    logic [W-1:0]            spec_val_s;
    logic [2:0]              spec_flags_s;
    logic [SIG_W-1:0]        big_sig_s, small_sig_s;
    logic                    big_sign_s, small_sign_s;
    logic signed [EI_W-1:0]  big_exp_s;
    logic [SIG_W:0]          add_s;
    logic                    add_sign_s, add_fin_s;
    logic [SIG_W-1:0]        norm_sig_s;
    logic signed [EI_W-1:0]  norm_exp_s;
    logic                    norm_fin_s;
    logic [W-1:0]            rnd_val_s;
    logic [2:0]              rnd_flags_s;
    logic                    res_wr_s;
    logic [W-1:0]            res_val_s;
    logic [2:0]              res_flags_s;

    assign sum   = sum_r;
    assign flags = flags_r;
    assign done  = done_r;
    assign busy  = busy_r;

    // Special-operand detection on the live inputs, in priority order.
    always_comb begin
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        ea = a[W-2:MAN_W];
        eb = b[W-2:MAN_W];
        fa = a[MAN_W-1:0];
        fb = b[MAN_W-1:0];
        sa = a[W-1];
        sb = b[W-1] ^ sub;
        a_nan  = (ea == EXP_ONES) && (fa != FRAC_ZERO);
        b_nan  = (eb == EXP_ONES) && (fb != FRAC_ZERO);
        a_inf  = (ea == EXP_ONES) && (fa == FRAC_ZERO);
        b_inf  = (eb == EXP_ONES) && (fb == FRAC_ZERO);
        a_zero = is_zero(ea, fa);
        b_zero = is_zero(eb, fb);
        spec_hit_s   = 1'b1;
        spec_flags_s = 3'b000;
        spec_val_s   = {W{1'b0}};
        if (a_nan || b_nan) begin
            spec_val_s = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_val_s   = QNAN;
            spec_flags_s = 3'b100;
        end else if (a_inf) begin
            spec_val_s = {sa, EXP_ONES, FRAC_ZERO};
        end else if (b_inf) begin
            spec_val_s = {sb, EXP_ONES, FRAC_ZERO};
        end else if (a_zero && b_zero) begin
            spec_val_s = {sa & sb, EXP_ZERO, FRAC_ZERO};
        end else if (a_zero) begin
            spec_val_s = {sb, b[W-2:0]};
        end else if (b_zero) begin
            spec_val_s = {sa, a[W-2:0]};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // Alignment: the smaller-exponent significand is shifted right with sticky.
    always_comb begin
        logic signed [EI_W-1:0] ea, eb;
        logic [SIG_W-1:0]       siga, sigb;
        logic                   sa, sb;
        ea   = eff_exp(a_r[W-2:MAN_W]);
        eb   = eff_exp(b_r[W-2:MAN_W]);
        siga = {a_r[W-2:MAN_W] != EXP_ZERO, a_r[MAN_W-1:0], 3'b000};
        sigb = {b_r[W-2:MAN_W] != EXP_ZERO, b_r[MAN_W-1:0], 3'b000};
        sa   = a_r[W-1];
        sb   = b_r[W-1] ^ sub_r;
        if (ea >= eb) begin
            big_sig_s    = siga;
            big_sign_s   = sa;
            big_exp_s    = ea;
            small_sig_s  = shr_sticky(sigb, ea - eb);
            small_sign_s = sb;
        end else begin
            big_sig_s    = sigb;
            big_sign_s   = sb;
            big_exp_s    = eb;
            small_sig_s  = shr_sticky(siga, eb - ea);
            small_sign_s = sa;
        end
    end

    // Sign-magnitude add; a subtract always takes the larger minus the smaller.
    always_comb begin
        if (sx_r == sy_r) begin
            add_s      = {1'b0, x_r} + {1'b0, y_r};
            add_sign_s = sx_r;
        end else if (x_r >= y_r) begin
            add_s      = {1'b0, x_r - y_r};
            add_sign_s = sx_r;
        end else begin
            add_s      = {1'b0, y_r - x_r};
            add_sign_s = sy_r;
        end
        // No left shift needed: zero, carry-out, normalised, or already at the subnormal floor.
        add_fin_s = (add_s == ADD_ZERO) || add_s[SIG_W] || add_s[SIG_W-1] ||
                    (SUB_EN && (exp_r == EI_ONE));
    end

    // One normalising left shift; stop once the leading bit lands or at the subnormal floor.
    always_comb begin
        norm_sig_s = {mant_r[SIG_W-2:0], 1'b0};
        norm_exp_s = exp_r - EI_ONE;
        norm_fin_s = norm_sig_s[SIG_W-1] || (norm_sig_s == SIG_ZERO) ||
                     (SUB_EN && (norm_exp_s == EI_ONE));
    end

    // Round-to-nearest-even, rounding-carry renormalisation, overflow and flush.
    always_comb begin
        logic [MAN_W+1:0]       rsig;
        logic [MAN_W-1:0]       rfrac;
        logic                   rhid, inexact, up;
        logic signed [EI_W-1:0] rexp;
        inexact = |mant_r[2:0];
        up      = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
        rsig    = {1'b0, mant_r[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, up};
        if (rsig[MAN_W+1]) begin
            rfrac = rsig[MAN_W:1];
            rhid  = 1'b1;
            rexp  = exp_r + EI_ONE;
        end else begin
            rfrac = rsig[MAN_W-1:0];
            rhid  = rsig[MAN_W];
            rexp  = exp_r;
        end
        if (rhid && (rexp >= EI_MAX)) begin
            rnd_val_s   = {sign_r, EXP_ONES, FRAC_ZERO};
            rnd_flags_s = 3'b011;
        end else if (!rhid) begin
            // Exact zero, or a subnormal result at exponent 1.
            rnd_val_s   = {sign_r, EXP_ZERO, rfrac};
            rnd_flags_s = {2'b00, inexact};
        end else if (rexp < EI_ONE) begin
            rnd_val_s   = {sign_r, EXP_ZERO, FRAC_ZERO};
            rnd_flags_s = 3'b001;
        end else begin
            rnd_val_s   = {sign_r, rexp[EXP_W-1:0], rfrac};
            rnd_flags_s = {2'b00, inexact};
        end
    end

    // Next-state logic.
    always_comb begin
        case (state_r)
            S_IDLE:  state_nx_s = (start && !spec_hit_s) ? S_ALIGN : S_IDLE;
            S_ALIGN: state_nx_s = S_ADD;
            S_ADD:   state_nx_s = add_fin_s ? S_ROUND : S_NORM;
            S_NORM:  state_nx_s = norm_fin_s ? S_ROUND : S_NORM;
            S_ROUND: state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Output decode: which result, if any, is written this cycle.
    always_comb begin
        case (state_r)
            S_IDLE: begin
                res_wr_s    = start & spec_hit_s;
                res_val_s   = spec_val_s;
                res_flags_s = spec_flags_s;
            end
            S_ROUND: begin
                res_wr_s    = 1'b1;
                res_val_s   = rnd_val_s;
                res_flags_s = rnd_flags_s;
            end
            default: begin
                res_wr_s    = 1'b0;
                res_val_s   = {W{1'b0}};
                res_flags_s = 3'b000;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_nx_s;
    end

    // Operand capture, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sub_r   <= 1'b0;
            x_r     <= SIG_ZERO;
            y_r     <= SIG_ZERO;
            mant_r  <= SIG_ZERO;
            sx_r    <= 1'b0;
            sy_r    <= 1'b0;
            sign_r  <= 1'b0;
            exp_r   <= {EI_W{1'b0}};
            sum_r   <= {W{1'b0}};
            flags_r <= 3'b000;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            done_r <= res_wr_s;
            busy_r <= (state_nx_s != S_IDLE);
            if (res_wr_s) begin
                sum_r   <= res_val_s;
                flags_r <= res_flags_s;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                    end
                end
                S_ALIGN: begin
                    x_r   <= big_sig_s;
                    y_r   <= small_sig_s;
                    sx_r  <= big_sign_s;
                    sy_r  <= small_sign_s;
                    exp_r <= big_exp_s;
                end
                S_ADD: begin
                    if (add_s == ADD_ZERO) begin
                        mant_r <= SIG_ZERO;
                        sign_r <= 1'b0;
                    end else if (add_s[SIG_W]) begin
                        mant_r <= {add_s[SIG_W:2], add_s[1] | add_s[0]};
                        exp_r  <= exp_r + EI_ONE;
                        sign_r <= add_sign_s;
                    end else begin
                        mant_r <= add_s[SIG_W-1:0];
                        sign_r <= add_sign_s;
                    end
                end
                S_NORM: begin
                    mant_r <= norm_sig_s;
                    exp_r  <= norm_exp_s;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_param.sv
// Directed self-checking bench for fpadd_param at binary32 (EXP_W=8, MAN_W=23).
// Expected values are hand-computed; cases that depend on FPADD_SUBNORMAL_EN
// select their expectation with the same macro.
module tb_fpadd_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a, b, sum;
    logic        done, busy;
    logic [2:0]  flags;
    int          check_cnt_r = 0;
    int          fail_cnt_r  = 0;

    fpadd_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub),
        .sum(sum), .done(done), .busy(busy), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        check_cnt_r++;
        if (got !== exp_v) begin
            fail_cnt_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp_v);
        end
    endtask

    // Pulse start for one edge, then count cycles until done (bounded).
    // cyc = 1 means done is high in the cycle right after the start edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          output int cyc);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a, b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  fl;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] va, input logic [31:0] vb,
                           input logic vs, input logic [31:0] vr, input logic [2:0] vf,
                           input int vc);
        vec_t v;
        v.name = n; v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.fl = vf; v.cyc = vc;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        int dones;
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sum",   sum,           32'h0);
        check_val("rst_flags", {29'd0, flags}, 32'h0);
        check_val("rst_done",  {31'd0, done},  32'h0);
        check_val("rst_busy",  {31'd0, busy},  32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        add_vec("one_plus_two",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 4);
        add_vec("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
        add_vec("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4);
        add_vec("rne_tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 4);
        add_vec("rne_tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 4);
        add_vec("one_minus_two",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 5);
        add_vec("cancel_23",      32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 27);
        add_vec("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1);
        add_vec("nan_operand",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 1);
        add_vec("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 1);
        add_vec("zero_minus_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 1);
        add_vec("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1);
        add_vec("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 4);
`ifdef FPADD_SUBNORMAL_EN
        add_vec("sub_plus_sub",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 4);
        add_vec("tiny_diff",      32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 3'b000, 4);
`else
        add_vec("sub_plus_sub",   32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000, 1);
        add_vec("tiny_diff",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 27);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, cyc);
            check_val({vecs[i].name, "_done"},  {31'd0, done},   32'h1);
            check_val({vecs[i].name, "_sum"},   sum,             vecs[i].res);
            check_val({vecs[i].name, "_flags"}, {29'd0, flags},  {29'd0, vecs[i].fl});
            check_val({vecs[i].name, "_cyc"},   cyc,             vecs[i].cyc);
            check_val({vecs[i].name, "_busy"},  {31'd0, busy},   32'h0);
            @(posedge clk); #1;
            check_val({vecs[i].name, "_pulse"}, {31'd0, done},   32'h0);
        end

        // A second start while busy must be ignored: exactly one done, first result kept.
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check_val("hs_busy", {31'd0, busy}, 32'h1);
        a = 32'h7F800000; b = 32'hFF800000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check_val("hs_one_done", dones, 1);
        check_val("hs_sum", sum, 32'h40400000);

        // Reset in the middle of NORM aborts the operation.
        run_op(32'h3F800000, 32'h40000000, 1'b0, cyc);
        a = 32'h3F800001; b = 32'h3F800000; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("mid_busy", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("abort_sum",   sum,            32'h0);
        check_val("abort_busy",  {31'd0, busy},  32'h0);
        check_val("abort_flags", {29'd0, flags}, 32'h0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check_val("abort_no_done", dones, 0);

        // Recovery after the abort.
        run_op(32'h3F800000, 32'h40000000, 1'b0, cyc);
        check_val("recover_sum", sum, 32'h40400000);
        check_val("recover_cyc", cyc, 4);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt_r, fail_cnt_r);
        $finish;
    end
endmodule

// File: doc/fpadd_param.md
# fpadd_param

Parametrised IEEE-754-style floating-point add/subtract unit: the next-generation adder for the datapath, generic in exponent and fraction width, with an add/subtract mode, round-to-nearest-even, status flags and a busy/start/done handshake. It is a multi-cycle FSM with iterative normalisation, one left shift per cycle. It sits wherever the team needs a single-issue FP adder, at binary16, binary32 or custom widths.

## Interface
- EXP_W, 8: exponent field width; at least 3.
- MAN_W, 23: stored fraction width, excluding the hidden bit; at least 2.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; returns the FSM to IDLE.
- start  input  1  request; sampled only in IDLE.
- a, b  input  EXP_W+MAN_W+1  operands, packed {sign, exp, frac}.
- sub  input  1  0: a+b, 1: a-b (b sign inverted at capture).
- sum  output  EXP_W+MAN_W+1  result; reset 0; held until the next result is written.
- done  output  1  one-cycle pulse when sum/flags are valid; reset 0.
- busy  output  1  high in every state except IDLE; reset 0.
- flags  output  3  {invalid, overflow, inexact}; reset 0; updated together with sum.

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND.
- IDLE
  - On start, capture a, b and sub into internal registers.
  - Special operand → write sum and flags, pulse done, stay IDLE.
  - Otherwise → ALIGN.
- Special-operand priority:
  - Any NaN → canonical qNaN {0, all-ones, 1, zeros}, invalid=0.
  - Inf + opposite-sign Inf → qNaN, invalid=1.
  - Single Inf, or same-sign Infs → that Inf.
  - Both zero → -0 if both effective signs are negative, else +0.
  - One zero → the other operand, with effective sign applied.
- ALIGN
  - Significand = {hidden, frac}, extended with guard, round and sticky bits.
  - Shift the smaller-exponent significand right by the exponent difference; shifted-out bits OR into sticky.
  - Differences ≥ MAN_W+3 leave only sticky.
- ADD: sign-magnitude add/subtract. On subtract, the larger magnitude minus the smaller; the result sign is the sign of the larger. Exact zero gives +0.
- NORM
  - Carry-out: shift right 1 (LSB into sticky), exp+1, → ROUND.
  - Leading bit set: → ROUND.
  - Otherwise shift left 1, exp-1, stay in NORM.
  - Zero result: → ROUND at once.
- ROUND
  - Round-to-nearest-even on guard/round/sticky; inexact = G|R|S.
  - A rounding carry renormalises in the same cycle.
  - exp ≥ all-ones → ±Inf, overflow=1, inexact=1.
  - Write sum and flags, pulse done, → IDLE.
- start while busy: ignored, not queued.
- reset mid-operation: abort, → IDLE, outputs to reset values; no done for the aborted request.

## Timing
- start is sampled at edge N.
- Special case: done is high in the cycle after edge N.
- Normal case: done is high in the cycle after edge N+3+s, where s is the number of left-shift NORM cycles (0..MAN_W+1). Carry-out and already-normalised results give s=0, so the minimum latency is 4 cycles.
- busy rises after edge N on the normal path and falls in the same cycle done is high.
- A new start is accepted in the same cycle done is high, because the FSM is already in IDLE.

## Configuration
- FPADD_SUBNORMAL_EN defined:
  - Subnormal inputs use hidden bit 0 and exponent 1.
  - NORM stops left-shifting at exponent 1 and emits a subnormal result.
  - Tiny results round normally.
- FPADD_SUBNORMAL_EN undefined:
  - Subnormal inputs are treated as same-sign zero.
  - Results below the minimum normal are flushed to same-sign zero with inexact=1.

## Test plan
All vectors use defaults EXP_W=8, MAN_W=23.
- 1.0 + 2.0: a=3F800000, b=40000000, sub=0 → sum=40400000, flags=000, done 4 cycles after start.
- 1.0 + 1.0: a=b=3F800000 → sum=40000000 via the carry-out path, 4 cycles.
- 1.0 - 1.0: a=b=3F800000, sub=1 → sum=00000000, flags=000.
- RNE tie: a=3F800000, b=33800000 → sum=3F800000, inexact=1.
- Specials and overflow:
  - a=7F800000, b=FF800000 → sum=7FC00000, invalid=1, done 1 cycle after start.
  - a=b=7F7FFFFF → sum=7F800000, overflow=1.
- Subnormal, handshake and reset: a=b=00000001.
  - With FPADD_SUBNORMAL_EN → 00000002.
  - Without FPADD_SUBNORMAL_EN → 00000000.
  - A second start while busy is ignored (exactly one done).
  - reset asserted in NORM → no done, sum=0, busy=0.
